// File: rtl/tdm_demux4_if.sv
// Slot-stream bus into the TDM demultiplexer and its parallel channel bank out.
interface tdm_demux4_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0]   din;
  logic               din_valid;
  logic               frame_sync;
  logic [4*WIDTH-1:0] j;
  logic               frame_valid;
  logic [1:0]         sel;
  logic               locked;
  logic               sync_err;

  // master: the serial link source, slave: the demultiplexer
  modport master (
    output din, din_valid, frame_sync,
    input  j, frame_valid, sel, locked, sync_err
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output j, frame_valid, sel, locked, sync_err
  );
endinterface

// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer: acquires frame alignment from a sync marker,
// assembles each frame in a shadow bank and publishes it whole on the channel bank.
module tdm_demux4 #(
  parameter int WIDTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  tdm_demux4_if.slave  bus
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t             state_p1, state_nx;
  logic [1:0]         sel_p1, sel_nx;
  logic [WIDTH-1:0]   shadow_p1 [0:3];
  logic [4*WIDTH-1:0] j_p1;
  logic               fv_p1;
  logic               err_p1;

  logic               wr_en;
  logic [1:0]         wr_idx;
  logic               complete;
  logic               misalign;

  always_comb begin
    state_nx = state_p1;
    sel_nx   = sel_p1;
    wr_en    = 1'b0;
    wr_idx   = sel_p1;
    complete = 1'b0;
    misalign = 1'b0;
    if (bus.din_valid) begin
      unique case (state_p1)
        HUNT: begin
          if (bus.frame_sync) begin
            wr_en    = 1'b1;
            wr_idx   = 2'd0;
            sel_nx   = 2'd1;
            state_nx = LOCKED;
          end
        end
        LOCKED: begin
          if (bus.frame_sync && (sel_p1 != 2'd0)) begin
            // Sync arrived mid-frame: drop the partial frame and realign here.
            misalign = 1'b1;
            wr_en    = 1'b1;
            wr_idx   = 2'd0;
            sel_nx   = 2'd1;
          end else begin
            wr_en    = 1'b1;
            wr_idx   = sel_p1;
            sel_nx   = sel_p1 + 2'd1;
            complete = (sel_p1 == 2'd3);
          end
        end
        default: state_nx = HUNT;
      endcase
    end
  end

  // Stage p1: state, shadow capture and output bank
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p1 <= HUNT;
      sel_p1   <= 2'd0;
      j_p1     <= '0;
      fv_p1    <= 1'b0;
      err_p1   <= 1'b0;
      for (int k = 0; k < 4; k++) shadow_p1[k] <= '0;
    end else begin
      state_p1 <= state_nx;
      sel_p1   <= sel_nx;
      fv_p1    <= complete;
      err_p1   <= misalign;
      if (wr_en) shadow_p1[wr_idx] <= bus.din;
      // Slot 3 bypasses the shadow so the frame is published on its capture edge.
      if (complete) j_p1 <= {bus.din, shadow_p1[2], shadow_p1[1], shadow_p1[0]};
    end
  end

  assign bus.j           = j_p1;
  assign bus.frame_valid = fv_p1;
  assign bus.sel         = sel_p1;
  assign bus.locked      = (state_p1 == LOCKED);
  assign bus.sync_err    = err_p1;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4: per-sample checks of sel/locked/sync_err and a
// frame scoreboard compared whenever frame_valid is seen.
module tb_tdm_demux4;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tdm_demux4_if #(.WIDTH(W)) bus ();

  tdm_demux4 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  logic [4*W-1:0] exp_q[$];
  logic [4*W-1:0] last_j;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame bank: either a scored frame arrives or j must hold its last value.
  task automatic chk_bank(input string tag, input bit exp_fv);
    logic [4*W-1:0] want;
    chk({tag, "_fv"}, 32'(bus.frame_valid), 32'(exp_fv));
    if (bus.frame_valid) begin
      chk({tag, "_qdepth"}, 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        want   = exp_q.pop_front();
        last_j = want;
      end else begin
        want = last_j;
      end
    end else begin
      want = last_j;
    end
    chk({tag, "_j"}, 32'(bus.j), 32'(want));
  endtask

  task automatic send(input string tag, input logic [W-1:0] d, input bit sync,
                      input logic [1:0] e_sel, input bit e_lock, input bit e_err, input bit e_fv);
    bus.din        = d;
    bus.din_valid  = 1'b1;
    bus.frame_sync = sync;
    @(posedge clk);
    #1;
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
    chk({tag, "_sel"}, 32'(bus.sel), 32'(e_sel));
    chk({tag, "_locked"}, 32'(bus.locked), 32'(e_lock));
    chk({tag, "_err"}, 32'(bus.sync_err), 32'(e_err));
    chk_bank(tag, e_fv);
  endtask

  task automatic idle(input string tag, input int n, input logic [1:0] e_sel, input bit e_lock);
    for (int i = 0; i < n; i++) begin
      bus.frame_sync = (i % 2 == 0); // sync without valid must be ignored
      bus.din        = 4'hF;
      @(posedge clk);
      #1;
      bus.frame_sync = 1'b0;
      chk({tag, "_idle_sel"}, 32'(bus.sel), 32'(e_sel));
      chk({tag, "_idle_locked"}, 32'(bus.locked), 32'(e_lock));
      chk({tag, "_idle_err"}, 32'(bus.sync_err), 32'd0);
      chk_bank({tag, "_idle"}, 1'b0);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_j"}, 32'(bus.j), 32'd0);
    chk({tag, "_fv"}, 32'(bus.frame_valid), 32'd0);
    chk({tag, "_sel"}, 32'(bus.sel), 32'd0);
    chk({tag, "_locked"}, 32'(bus.locked), 32'd0);
    chk({tag, "_err"}, 32'(bus.sync_err), 32'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.din        = '0;
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
    last_j         = '0;

    // Reset held two cycles, then hunt with unsynced samples
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst_n = 1'b1;
    send("hunt0", 4'h5, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    send("hunt1", 4'h6, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    send("hunt2", 4'h7, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

    // Acquire and one frame
    send("acq0", 4'h0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    send("acq1", 4'h1, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0);
    send("acq2", 4'h1, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(16'h1110);
    send("acq3", 4'h1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1);

    // Two frames at full rate
    send("b2bA0", 4'hA, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    send("b2bA1", 4'hB, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0);
    send("b2bA2", 4'hC, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(16'hDCBA);
    send("b2bA3", 4'hD, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
    send("b2bB0", 4'h3, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    send("b2bB1", 4'h5, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0);
    send("b2bB2", 4'h7, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(16'h9753);
    send("b2bB3", 4'h9, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1);

    // Third frame with two idle cycles between samples
    idle("gap0", 2, 2'd0, 1'b1);
    send("gapC0", 4'h8, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    idle("gap1", 2, 2'd1, 1'b1);
    send("gapC1", 4'h4, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0);
    idle("gap2", 2, 2'd2, 1'b1);
    send("gapC2", 4'h2, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0);
    idle("gap3", 2, 2'd3, 1'b1);
    exp_q.push_back(16'h1248);
    send("gapC3", 4'h1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1);

    // Misplaced sync after two slots
    send("mis0", 4'h1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    send("mis1", 4'h2, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0);
    send("misS", 4'h9, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0);
    send("mis2", 4'h3, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0);
    send("mis3", 4'h4, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(16'h5439);
    send("mis4", 4'h5, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1);

    // Free-running: eight samples, no further sync
    for (int f = 0; f < 2; f++) begin
      logic [W-1:0] base;
      base = W'(4 * f + 6);
      send("free0", base,        1'b0, 2'd1, 1'b1, 1'b0, 1'b0);
      send("free1", base + 4'd1, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0);
      send("free2", base + 4'd2, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0);
      exp_q.push_back({base + 4'd3, base + 4'd2, base + 4'd1, base});
      send("free3", base + 4'd3, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
    end

    // Mid-frame reset after slot 2, then slot 3 must be ignored
    send("mrst0", 4'h1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    send("mrst1", 4'h2, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0);
    send("mrst2", 4'h3, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    last_j = '0;
    chk_reset_vals("mrst");
    send("mrst3", 4'h4, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

    // Completion edge coinciding with reset is cancelled
    send("canc0", 4'h7, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    send("canc1", 4'h7, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0);
    send("canc2", 4'h7, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0);
    bus.din       = 4'h7;
    bus.din_valid = 1'b1;
    rst_n         = 1'b0;
    @(posedge clk);
    #1;
    bus.din_valid = 1'b0;
    rst_n         = 1'b1;
    chk_reset_vals("canc");

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end
endmodule
